uart_cmd_responder: RTL and testbench
=====================================

# uart_cmd_responder

Byte-level command responder between the UART core and the cracker's shared RAM. It lets a host PC write byte blocks into RAM, read them back, and poll a status byte over one serial link. It consumes received bytes from the UART core's rx handshake and produces replies through its tx handshake. It answers host commands; it never starts a transfer on its own.

## Interface
- ADDR_WIDTH, 8: RAM address width, legal range 1..8; the low ADDR_WIDTH bits of the address byte are used.
- TIMEOUT_CYCLES, 50_000_000: inter-byte timeout in clk cycles; used only with UART_CMD_TIMEOUT_EN.

- clk  in  1  system clock; every register updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from UART core
- rx_ready  in  1  UART core holds a received byte
- rx_ready_clr  out  1  combinational; high for exactly the cycle a byte is consumed
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  UART transmitter busy
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_data  out  8  RAM write data
- ram_we  out  1  one-cycle write strobe
- ram_q  in  8  RAM read data; valid one cycle after ram_addr changes
- status  in  8  value returned by the 'S' command
- busy  out  1  high whenever the FSM is not in IDLE
- cmd_done  out  1  one-cycle pulse when a command completes successfully
- err  out  1  one-cycle pulse when a NAK is issued

## Operation
- Opcodes, sent as the first byte of a command:
  - 0x57 'W' addr cnt d0..dN-1: N = cnt+1 (1..256). Writes the data bytes to RAM, then replies ACK 0x06.
  - 0x52 'R' addr cnt: replies with N = cnt+1 bytes read from RAM starting at addr.
  - 0x53 'S': replies with one byte, the status value sampled in the cycle the opcode is consumed.
  - Any other opcode: replies NAK 0x15 and pulses err.
- States: IDLE, GET_ADDR, GET_CNT, WR_DATA, WR_STB, RD_ADDR, RD_WAIT, TX_REQ, TX_GAP.
- Receiving states are IDLE, GET_ADDR, GET_CNT and WR_DATA.
  - In these states, rx_ready=1 consumes the byte: rx_ready_clr=rx_ready, and the state advances on the same edge.
  - In all other states rx_ready is ignored and rx_ready_clr=0.
- Write path:
  - WR_DATA accepts a byte, registers ram_addr=addr and ram_data=rx_data, then moves to WR_STB.
  - WR_STB: ram_we=1 for one cycle; addr increments, the remaining count decrements.
  - Then back to WR_DATA, or to ACK transmission after the last byte.
- Read path:
  - RD_ADDR drives ram_addr.
  - RD_WAIT lasts one cycle for RAM latency.
  - TX_REQ latches tx_data=ram_q, then addr increments and the remaining count decrements.
  - After TX_GAP: RD_ADDR if bytes remain, otherwise IDLE.
- Transmit handshake:
  - TX_REQ waits for tx_busy=0, then pulses tx_start for one cycle with tx_data stable.
  - TX_GAP lasts exactly one cycle, so tx_busy is never sampled in the cycle right after tx_start.
  - tx_data holds its value until the next TX_REQ issue.
- Address arithmetic: increments modulo 2^ADDR_WIDTH. A block that runs past the top address wraps to 0, with no error.
- cmd_done pulses on the return to IDLE after an ACK, after the last 'R' byte, or after the 'S' reply. It never pulses after a NAK.
- Reset mid-command: the FSM returns to IDLE immediately and the partial command is discarded. Data already written to RAM stays.

## Timing
- Reset values:
  - rx_ready_clr=0, tx_start=0, tx_data=0x00
  - ram_addr=0, ram_data=0x00, ram_we=0
  - busy=0, cmd_done=0, err=0
  - FSM in IDLE
- Write latency: ram_we asserts 1 cycle after the data byte is consumed.
- Read latency: tx_start asserts at the earliest 3 cycles after entering RD_ADDR (RD_ADDR, RD_WAIT, TX_REQ), and later if tx_busy is high.
- At most one tx_start every 2 cycles; a new tx_start waits for tx_busy=0.
- Bytes arriving while the block is transmitting are neither consumed nor cleared. The host must wait for the full reply before sending the next command.

## Configuration
- UART_CMD_TIMEOUT_EN defined:
  - A counter runs in GET_ADDR, GET_CNT and WR_DATA and clears on each consumed byte.
  - When it reaches TIMEOUT_CYCLES, the block sends NAK 0x15, pulses err, and returns to IDLE.
- Undefined: those states wait indefinitely, and the counter logic is absent.

## Test plan
- 'W' 0x10 0x02 AA BB CC -> three ram_we pulses at 0x10/0x11/0x12 with data AA/BB/CC; reply 0x06; one cmd_done.
- Preload RAM 0x20..0x23 = 01 02 03 04; send 'R' 0x20 0x03 -> tx bytes 01 02 03 04 in order; no tx_start while tx_busy=1.
- status=0x5A, send 'S' -> single reply 0x5A; busy low afterwards.
- Opcode 0x41 -> reply 0x15, one err pulse, no ram_we, no cmd_done.
- 'W' 0xFF 0x01 11 22 -> writes at 0xFF, then at 0x00 (wrap); reply 0x06.
- Assert rst_n low after 'W' 0x00: all outputs return to reset values, busy=0. A following 'S' still works.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 'W' 0x00, then idle 100 cycles -> reply 0x15, err pulse, return to IDLE.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: byte-level command responder between the UART core and
// the shared RAM. The host can write byte blocks ('W'), read them back ('R')
// and poll a status byte ('S'). Unknown opcodes get a NAK.
//
// Optional feature macro: UART_CMD_TIMEOUT_EN
//   When defined, an inter-byte timeout aborts a half-received command with a
//   NAK after TIMEOUT_CYCLES idle clocks. When undefined, the counter is absent.

module uart_cmd_responder #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    output logic                  rx_ready_clr,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_data,
    output logic                  ram_we,
    input  logic [7:0]            ram_q,
    input  logic [7:0]            status,
    output logic                  busy,
    output logic                  cmd_done,
    output logic                  err
);

    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] OP_STATUS = 8'h53;
    localparam logic [7:0] BYTE_ACK  = 8'h06;
    localparam logic [7:0] BYTE_NAK  = 8'h15;

    // Elaboration-time parameter sanity checks
    generate
        if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 8)) begin : g_bad_addr_width
            $error("uart_cmd_responder: ADDR_WIDTH must be in 1..8");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("uart_cmd_responder: TIMEOUT_CYCLES must be positive");
        end
    endgenerate

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GET_ADDR = 4'd1,
        GET_CNT  = 4'd2,
        WR_DATA  = 4'd3,
        WR_STB   = 4'd4,
        RD_ADDR  = 4'd5,
        RD_WAIT  = 4'd6,
        TX_REQ   = 4'd7,
        TX_GAP   = 4'd8
    } state_t;

    // What the current command will reply with once it reaches TX_REQ
    typedef enum logic [1:0] {
        MODE_WR  = 2'd0,
        MODE_RD  = 2'd1,
        MODE_ST  = 2'd2,
        MODE_NAK = 2'd3
    } mode_t;

    state_t                  state_r,     state_nxt_s;
    mode_t                   mode_r,      mode_nxt_s;
    logic [ADDR_WIDTH-1:0]   addr_r,      addr_nxt_s;
    logic [7:0]              cnt_r,       cnt_nxt_s;      // bytes remaining minus one
    logic                    more_r,      more_nxt_s;     // read bytes still to send
    logic [7:0]              tx_byte_r,   tx_byte_nxt_s;  // ACK/NAK/status reply byte
    logic [7:0]              tx_data_r,   tx_data_nxt_s;
    logic                    tx_start_r,  tx_start_nxt_s;
    logic [ADDR_WIDTH-1:0]   ram_addr_r,  ram_addr_nxt_s;
    logic [7:0]              ram_data_r,  ram_data_nxt_s;
    logic                    ram_we_r,    ram_we_nxt_s;
    logic                    busy_r;
    logic                    cmd_done_r,  cmd_done_nxt_s;
    logic                    err_r,       err_nxt_s;
    logic                    rx_ready_clr_s;
    logic                    timeout_s;

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [31:0] tmo_cnt_r;
    logic        wait_state_s;

    assign wait_state_s = (state_r == GET_ADDR) || (state_r == GET_CNT) || (state_r == WR_DATA);
    assign timeout_s    = wait_state_s && (tmo_cnt_r >= TMO_LIMIT);

    // Inter-byte idle counter: runs while waiting for command bytes, clears on each byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= 32'd0;
        end else if (wait_state_s && !rx_ready && (tmo_cnt_r < TMO_LIMIT)) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end else begin
            tmo_cnt_r <= 32'd0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic for the command FSM
    always_comb begin
        state_nxt_s    = state_r;
        mode_nxt_s     = mode_r;
        addr_nxt_s     = addr_r;
        cnt_nxt_s      = cnt_r;
        more_nxt_s     = more_r;
        tx_byte_nxt_s  = tx_byte_r;
        tx_data_nxt_s  = tx_data_r;
        tx_start_nxt_s = 1'b0;
        ram_addr_nxt_s = ram_addr_r;
        ram_data_nxt_s = ram_data_r;
        ram_we_nxt_s   = 1'b0;
        cmd_done_nxt_s = 1'b0;
        err_nxt_s      = 1'b0;
        rx_ready_clr_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (rx_ready) begin
                    rx_ready_clr_s = 1'b1;
                    case (rx_data)
                        OP_WRITE: begin
                            mode_nxt_s  = MODE_WR;
                            state_nxt_s = GET_ADDR;
                        end
                        OP_READ: begin
                            mode_nxt_s  = MODE_RD;
                            state_nxt_s = GET_ADDR;
                        end
                        OP_STATUS: begin
                            // status is captured now, not when the reply goes out
                            mode_nxt_s    = MODE_ST;
                            tx_byte_nxt_s = status;
                            state_nxt_s   = TX_REQ;
                        end
                        default: begin
                            mode_nxt_s    = MODE_NAK;
                            tx_byte_nxt_s = BYTE_NAK;
                            state_nxt_s   = TX_REQ;
                        end
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            GET_ADDR: begin
                if (rx_ready) begin
                    rx_ready_clr_s = 1'b1;
                    addr_nxt_s     = rx_data[ADDR_WIDTH-1:0];
                    state_nxt_s    = GET_CNT;
                end else if (timeout_s) begin
                    mode_nxt_s    = MODE_NAK;
                    tx_byte_nxt_s = BYTE_NAK;
                    state_nxt_s   = TX_REQ;
                end else begin
                    state_nxt_s = GET_ADDR;
                end
            end

            GET_CNT: begin
                if (rx_ready) begin
                    rx_ready_clr_s = 1'b1;
                    cnt_nxt_s      = rx_data;
                    if (mode_r == MODE_RD) begin
                        // present the first read address for the whole RD_ADDR cycle
                        ram_addr_nxt_s = addr_r;
                        state_nxt_s    = RD_ADDR;
                    end else begin
                        state_nxt_s = WR_DATA;
                    end
                end else if (timeout_s) begin
                    mode_nxt_s    = MODE_NAK;
                    tx_byte_nxt_s = BYTE_NAK;
                    state_nxt_s   = TX_REQ;
                end else begin
                    state_nxt_s = GET_CNT;
                end
            end

            WR_DATA: begin
                if (rx_ready) begin
                    rx_ready_clr_s = 1'b1;
                    ram_addr_nxt_s = addr_r;
                    ram_data_nxt_s = rx_data;
                    ram_we_nxt_s   = 1'b1;
                    state_nxt_s    = WR_STB;
                end else if (timeout_s) begin
                    mode_nxt_s    = MODE_NAK;
                    tx_byte_nxt_s = BYTE_NAK;
                    state_nxt_s   = TX_REQ;
                end else begin
                    state_nxt_s = WR_DATA;
                end
            end

            WR_STB: begin
                // ram_we is high during this cycle; step to the next byte slot
                addr_nxt_s = addr_r + ADDR_WIDTH'(1);
                if (cnt_r == 8'd0) begin
                    tx_byte_nxt_s = BYTE_ACK;
                    state_nxt_s   = TX_REQ;
                end else begin
                    cnt_nxt_s   = cnt_r - 8'd1;
                    state_nxt_s = WR_DATA;
                end
            end

            RD_ADDR: begin
                state_nxt_s = RD_WAIT;
            end

            RD_WAIT: begin
                state_nxt_s = TX_REQ;
            end

            TX_REQ: begin
                if (!tx_busy) begin
                    tx_start_nxt_s = 1'b1;
                    state_nxt_s    = TX_GAP;
                    if (mode_r == MODE_RD) begin
                        tx_data_nxt_s = ram_q;
                        addr_nxt_s    = addr_r + ADDR_WIDTH'(1);
                        more_nxt_s    = (cnt_r != 8'd0);
                        cnt_nxt_s     = cnt_r - 8'd1;
                    end else begin
                        tx_data_nxt_s = tx_byte_r;
                        more_nxt_s    = 1'b0;
                    end
                    if (mode_r == MODE_NAK) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = TX_REQ;
                end
            end

            TX_GAP: begin
                // tx_start is high this cycle; tx_busy is deliberately not looked at
                if (more_r) begin
                    ram_addr_nxt_s = addr_r;
                    state_nxt_s    = RD_ADDR;
                end else begin
                    cmd_done_nxt_s = (mode_r != MODE_NAK);
                    state_nxt_s    = IDLE;
                end
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            mode_r     <= MODE_WR;
            addr_r     <= '0;
            cnt_r      <= 8'd0;
            more_r     <= 1'b0;
            tx_byte_r  <= 8'h00;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            ram_addr_r <= '0;
            ram_data_r <= 8'h00;
            ram_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            cmd_done_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mode_r     <= mode_nxt_s;
            addr_r     <= addr_nxt_s;
            cnt_r      <= cnt_nxt_s;
            more_r     <= more_nxt_s;
            tx_byte_r  <= tx_byte_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            ram_addr_r <= ram_addr_nxt_s;
            ram_data_r <= ram_data_nxt_s;
            ram_we_r   <= ram_we_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            cmd_done_r <= cmd_done_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    assign rx_ready_clr = rx_ready_clr_s;
    assign tx_data      = tx_data_r;
    assign tx_start     = tx_start_r;
    assign ram_addr     = ram_addr_r;
    assign ram_data     = ram_data_r;
    assign ram_we       = ram_we_r;
    assign busy         = busy_r;
    assign cmd_done     = cmd_done_r;
    assign err          = err_r;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Testbench for uart_cmd_responder: directed host commands, a behavioural RAM
// and UART transmitter, and a scoreboard of expected tx bytes and RAM writes
// checked by an independent monitor.

module tb_uart_cmd_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ready_clr;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic [7:0] ram_q;
    logic [7:0] status;
    logic       busy;
    logic       cmd_done;
    logic       err;

    uart_cmd_responder #(
        .ADDR_WIDTH     (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_ready_clr (rx_ready_clr),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_we       (ram_we),
        .ram_q        (ram_q),
        .status       (status),
        .busy         (busy),
        .cmd_done     (cmd_done),
        .err          (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int last_done = 0;
    int last_err  = 0;

    logic [7:0]  exp_tx_q[$];
    logic [15:0] exp_we_q[$];   // {addr, data}
    logic [7:0]  mem [0:255];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM with one cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // UART transmitter: busy for 6 cycles after each tx_start
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (6) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: compares every transmitted byte and RAM write against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                check("tx_busy_at_start", 32'(tx_busy), 32'd0);
                if (exp_tx_q.size() == 0) begin
                    check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    check("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
                end
            end
            if (ram_we) begin
                if (exp_we_q.size() == 0) begin
                    check("we_unexpected", {16'h0, ram_addr, ram_data}, 32'hFFFF_FFFF);
                end else begin
                    check("ram_write", {16'h0, ram_addr, ram_data}, 32'(exp_we_q.pop_front()));
                end
            end
            if (err)      err_cnt++;
            if (cmd_done) done_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (rx_ready_clr) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rx_consume", 32'(got), 32'd1);
        if (got) begin
            @(posedge clk);
            #1;
        end
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input int exp_done, input int exp_err, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        check({tag, "_cmd_done"}, 32'(done_cnt - last_done), 32'(exp_done));
        check({tag, "_err"}, 32'(err_cnt - last_err), 32'(exp_err));
        check({tag, "_tx_q_empty"}, 32'(exp_tx_q.size()), 32'd0);
        check({tag, "_we_q_empty"}, 32'(exp_we_q.size()), 32'd0);
        last_done = done_cnt;
        last_err  = err_cnt;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_start"},     32'(tx_start),     32'd0);
        check({tag, "_tx_data"},      32'(tx_data),      32'h00);
        check({tag, "_ram_addr"},     32'(ram_addr),     32'h00);
        check({tag, "_ram_data"},     32'(ram_data),     32'h00);
        check({tag, "_ram_we"},       32'(ram_we),       32'd0);
        check({tag, "_busy"},         32'(busy),         32'd0);
        check({tag, "_cmd_done"},     32'(cmd_done),     32'd0);
        check({tag, "_err"},          32'(err),          32'd0);
        check({tag, "_rx_ready_clr"}, 32'(rx_ready_clr), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        status   = 8'h00;
        repeat (3) @(negedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 'W' 0x10 0x02 AA BB CC
        exp_we_q.push_back({8'h10, 8'hAA});
        exp_we_q.push_back({8'h11, 8'hBB});
        exp_we_q.push_back({8'h12, 8'hCC});
        exp_tx_q.push_back(8'h06);
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_idle(1, 0, "w_basic");

        // Preload 0x20..0x23 = 01 02 03 04
        exp_we_q.push_back({8'h20, 8'h01});
        exp_we_q.push_back({8'h21, 8'h02});
        exp_we_q.push_back({8'h22, 8'h03});
        exp_we_q.push_back({8'h23, 8'h04});
        exp_tx_q.push_back(8'h06);
        send_byte(8'h57); send_byte(8'h20); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_idle(1, 0, "w_preload");

        // 'R' 0x20 0x03 -> 01 02 03 04, paced by tx_busy
        exp_tx_q.push_back(8'h01);
        exp_tx_q.push_back(8'h02);
        exp_tx_q.push_back(8'h03);
        exp_tx_q.push_back(8'h04);
        send_byte(8'h52); send_byte(8'h20); send_byte(8'h03);
        wait_idle(1, 0, "r_block");

        // 'R' 0x12 0x00 -> single byte CC
        exp_tx_q.push_back(8'hCC);
        send_byte(8'h52); send_byte(8'h12); send_byte(8'h00);
        wait_idle(1, 0, "r_single");

        // 'S' with status 0x5A; status changes right after the opcode is taken
        status = 8'h5A;
        exp_tx_q.push_back(8'h5A);
        send_byte(8'h53);
        status = 8'h00;
        wait_idle(1, 0, "s_cmd");
        check("s_busy_after", 32'(busy), 32'd0);

        // Unknown opcode 0x41 -> NAK
        exp_tx_q.push_back(8'h15);
        send_byte(8'h41);
        wait_idle(0, 1, "nak");

        // 'W' 0xFF 0x01 11 22 wraps to 0x00
        exp_we_q.push_back({8'hFF, 8'h11});
        exp_we_q.push_back({8'h00, 8'h22});
        exp_tx_q.push_back(8'h06);
        send_byte(8'h57); send_byte(8'hFF); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22);
        wait_idle(1, 0, "w_wrap");

        // 'R' 0xFF 0x01 -> 11 22 across the wrap
        exp_tx_q.push_back(8'h11);
        exp_tx_q.push_back(8'h22);
        send_byte(8'h52); send_byte(8'hFF); send_byte(8'h01);
        wait_idle(1, 0, "r_wrap");

        // Reset in the middle of 'W' 0x00
        send_byte(8'h57); send_byte(8'h00);
        check("mid_busy_before_reset", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_values("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        status = 8'hC3;
        exp_tx_q.push_back(8'hC3);
        send_byte(8'h53);
        wait_idle(1, 0, "s_after_reset");

`ifdef UART_CMD_TIMEOUT_EN
        // 'W' 0x00 then silence -> NAK after the timeout
        exp_tx_q.push_back(8'h15);
        send_byte(8'h57); send_byte(8'h00);
        wait_idle(0, 1, "timeout");
`endif

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
